ahb_burst_master: RTL and testbench
===================================

# ahb_burst_master

Initiator-side AHB-Lite read engine for the I-cache refill path. Accepts a single-word or 4-beat line-fill request from the cache controller, drives the AHB address/control phase (NONSEQ then SEQ, WRAP4 wrap within the 16-byte line), samples returned data in the data phase and hands each word back with its line offset. Pairs with the cache's responder-side transfer logic and drives the same `interface_pkg` encodings.

## Interface
- `WRAP4_BOUNDARY_MASK`, 32'hFFFF_FFF0, line-base mask for WRAP4 bursts
- `HSIZE_WORD`, 3'b010, fixed transfer size (32-bit)
- `clk`  in  1  system clock, all state on rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  fetch request present
- `req_addr`  in  32  request byte address; bits [1:0] ignored
- `req_burst`  in  3  `BURST_TYPES`: SINGLE or WRAP4 only
- `req_ready`  out  1  engine idle, request accepted on `req_valid && req_ready`
- `haddr`  out  32  AHB address
- `htrans`  out  2  `TRANS_TYPES`
- `hburst`  out  3  `BURST_TYPES`
- `hwrite`  out  1  constant 0
- `hsize`  out  3  constant `HSIZE_WORD`
- `hready`  in  1  AHB transfer-complete
- `hresp`  in  1  AHB error response
- `hrdata`  in  32  AHB read data
- `rdata_valid`  out  1  one-cycle pulse per returned beat
- `rdata`  out  32  returned word
- `rdata_offset`  out  4  byte offset of word within line (0,4,8,C)
- `rdata_last`  out  1  with `rdata_valid`: final beat of request
- `rdata_err`  out  1  with `rdata_valid`: beat ended with ERROR

## Operation
- Reset values: `htrans`=IDLE, `haddr`=0, `hburst`=SINGLE, `hwrite`=0, `hsize`=`HSIZE_WORD`, `req_ready`=1, `rdata_valid`/`rdata_last`/`rdata_err`=0, `rdata`=0, `rdata_offset`=0.
- States: IDLE, ADDR (address phase in flight, data phase of previous beat may overlap), DATA (last data phase, no address pending).
- IDLE: `req_ready`=1. On accept: latch base=`req_addr & WRAP4_BOUNDARY_MASK`, offset=`{req_addr[3:2],2'b00}`, burst type; go ADDR with `htrans`=NONSEQ, `haddr`=base+offset.
- ADDR, `hready`=1: beat's address phase completes. WRAP4 with <4 addresses issued: offset=(offset+4)&4'hC, `htrans`=SEQ, stay ADDR. Else `htrans`=IDLE, go DATA.
- ADDR/DATA, `hready`=0: `haddr`, `htrans`, `hburst` held unchanged (AHB rule); no data sampled.
- Data phase of a beat = cycle(s) after its address phase completes; `hrdata` sampled on the edge where `hready`=1.
- DATA: on last beat sampled go IDLE.
- Error: `hresp`=1 with `hready`=0 (first ERROR cycle) -> drive `htrans`=IDLE next cycle, cancel remaining beats; on second cycle (`hready`=1) report beat with `rdata_err`=1, `rdata_last`=1; go IDLE.
- `req_burst` values other than SINGLE/WRAP4 treated as SINGLE.
- Offsets are 4-bit; base unchanged across burst (no carry out of line).

## Timing
- All outputs registered.
- Accept at edge 0 -> NONSEQ visible cycle 1 -> zero-wait data sampled end of cycle 2 -> `rdata_valid` cycle 3.
- WRAP4 zero-wait: addresses cycles 1-4, data sampled cycles 2-5, `rdata_valid` cycles 3-6, `rdata_last` cycle 6; `req_ready` high cycle 6; next NONSEQ earliest cycle 7.
- SINGLE zero-wait: `rdata_valid`+`rdata_last` cycle 3, `req_ready` high cycle 3.
- Each `hready`=0 cycle adds exactly one cycle to all later events.
- Reset mid-burst: all outputs to reset values immediately (async); in-flight beats discarded, no `rdata_valid`.

## Structure
- `interface_pkg`: `BURST_TYPES`, `TRANS_TYPES` (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11), `WRAP4_BOUNDARY_MASK`, `HSIZE_WORD`, state enum `MASTER_STATES`.
- One sub-module: `ahb_wrap_addr_gen` — base/offset registers, load/advance/hold controls, beat counter, outputs `haddr` and issued-count.
- Data-return tracking (pending offset, last/err flags) stays in top.

## Test plan
- WRAP4 `req_addr`=0x1008, zero wait -> `haddr` 0x1008,0x100C,0x1000,0x1004; `htrans` NONSEQ,SEQ,SEQ,SEQ,IDLE; `rdata_offset` 8,C,0,4; `rdata_last` cycle 6.
- SINGLE `req_addr`=0x2006 -> `haddr`=0x2004, NONSEQ one cycle then IDLE; one `rdata_valid` cycle 3 with `rdata_last`=1, offset 4.
- WRAP4 0x3000, `hready`=0 for 2 cycles on beat 2 -> `haddr`=0x3008/SEQ held 2 extra cycles; `rdata_last` cycle 8; data order unchanged.
- WRAP4 0x4004, ERROR on beat 1 -> `htrans`=IDLE after first ERROR cycle, single `rdata_valid` with `rdata_err`=1, `rdata_last`=1, offset 4; `req_ready`=1 next cycle.
- `rstn` low in cycle 3 of WRAP4 -> `htrans`=IDLE, `rdata_valid`=0 immediately; after release new SINGLE 0x5000 completes normally.
- Back-to-back: second request held with `req_valid`=1 -> accepted cycle 6, NONSEQ cycle 7.

Source files
------------

// File: rtl/interface_pkg.sv
// interface_pkg: AHB-Lite encodings shared by the refill initiator and the cache responder.
// Latency: none, types and constants only.
// Backpressure: not applicable.
package interface_pkg;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'b000,
    BURST_INCR   = 3'b001,
    BURST_WRAP4  = 3'b010,
    BURST_INCR4  = 3'b011,
    BURST_WRAP8  = 3'b100,
    BURST_INCR8  = 3'b101,
    BURST_WRAP16 = 3'b110,
    BURST_INCR16 = 3'b111
  } BURST_TYPES;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } TRANS_TYPES;

  // IDLE: waiting for a request; ADDR: an address phase is on the bus (a data
  // phase may overlap); DATA: only the final data phase remains.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } MASTER_STATES;

  localparam logic [31:0] WRAP4_BOUNDARY_MASK = 32'hFFFF_FFF0;
  localparam logic [2:0]  HSIZE_WORD          = 3'b010;
  localparam logic [2:0]  WRAP4_BEATS         = 3'd4;

  // Next word offset inside a 16-byte line; wraps from 0xC back to 0x0.
  function automatic logic [3:0] wrap4_next_offset(input logic [3:0] off);
    return (off + 4'd4) & 4'hC;
  endfunction

endpackage

// File: rtl/ahb_wrap_addr_gen.sv
// ahb_wrap_addr_gen: line base / word offset registers producing haddr for SINGLE and WRAP4 bursts.
// Latency: haddr reflects a load or advance on the cycle after the controlling edge.
// Backpressure: holds its address whenever neither load nor advance is asserted.
module ahb_wrap_addr_gen
  import interface_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic [31:0] load_addr,
  input  logic        advance,
  output logic [31:0] haddr,
  output logic [2:0]  issued
);

  logic [31:0] base_q;
  logic [3:0]  off_q;
  logic [2:0]  cnt_q;

  // Base is fixed for the whole burst; only the offset moves, so no carry leaves the line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_q <= '0;
      off_q  <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      base_q <= load_addr & WRAP4_BOUNDARY_MASK;
      off_q  <= {load_addr[3:2], 2'b00};
      cnt_q  <= 3'd1;
    end else if (advance) begin
      off_q  <= wrap4_next_offset(off_q);
      cnt_q  <= cnt_q + 3'd1;
    end
  end

  assign haddr  = base_q | {28'd0, off_q};
  assign issued = cnt_q;

endmodule

// File: rtl/ahb_burst_master.sv
// ahb_burst_master: AHB-Lite read initiator for I-cache refill, SINGLE or WRAP4 line fills.
// Latency: NONSEQ one cycle after accept; each word returned the cycle after its data phase ends.
// Backpressure: hready low freezes address/control and data capture; req_ready low while busy.
module ahb_burst_master
  import interface_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_burst,
  output logic        req_ready,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic [2:0]  hburst,
  output logic        hwrite,
  output logic [2:0]  hsize,
  input  logic        hready,
  input  logic        hresp,
  input  logic [31:0] hrdata,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  output logic [3:0]  rdata_offset,
  output logic        rdata_last,
  output logic        rdata_err
);

  MASTER_STATES state_q, state_d;
  TRANS_TYPES   htrans_q, htrans_d;
  BURST_TYPES   hburst_q, hburst_d;

  // Data-phase tracking: pend_q marks a beat whose address completed and whose data is owed.
  logic        pend_q, pend_d;
  logic [3:0]  pend_off_q, pend_off_d;

  logic        rv_q, rv_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  roff_q, roff_d;
  logic        last_q, last_d;
  logic        err_q, err_d;

  logic        ag_load;
  logic        ag_adv;
  logic [31:0] ag_haddr;
  logic [2:0]  ag_issued;

  ahb_wrap_addr_gen u_addr_gen (
    .clk       (clk),
    .rstn      (rstn),
    .load      (ag_load),
    .load_addr (req_addr),
    .advance   (ag_adv),
    .haddr     (ag_haddr),
    .issued    (ag_issued)
  );

  // Next-state and next-output decode; every register holds unless a branch changes it.
  always_comb begin
    state_d    = state_q;
    htrans_d   = htrans_q;
    hburst_d   = hburst_q;
    pend_d     = pend_q;
    pend_off_d = pend_off_q;
    rv_d       = 1'b0;
    rdata_d    = rdata_q;
    roff_d     = roff_q;
    last_d     = 1'b0;
    err_d      = 1'b0;
    ag_load    = 1'b0;
    ag_adv     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          ag_load  = 1'b1;
          htrans_d = TRANS_NONSEQ;
          hburst_d = (req_burst == BURST_WRAP4) ? BURST_WRAP4 : BURST_SINGLE;
          pend_d   = 1'b0;
          state_d  = ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (hready) begin
          // The previous beat's data phase ends on the same edge as this address phase.
          if (pend_q) begin
            rv_d    = 1'b1;
            rdata_d = hrdata;
            roff_d  = pend_off_q;
            err_d   = hresp;
          end
          pend_d     = 1'b1;
          pend_off_d = ag_haddr[3:0];
          if (hburst_q == BURST_WRAP4 && ag_issued < WRAP4_BEATS) begin
            ag_adv   = 1'b1;
            htrans_d = TRANS_SEQ;
          end else begin
            htrans_d = TRANS_IDLE;
            state_d  = ST_DATA;
          end
        end else if (hresp && pend_q) begin
          // First ERROR cycle: withdraw the pending address and drop the remaining beats.
          htrans_d = TRANS_IDLE;
          state_d  = ST_DATA;
        end
      end

      ST_DATA: begin
        if (hready) begin
          rv_d    = 1'b1;
          rdata_d = hrdata;
          roff_d  = pend_off_q;
          last_d  = 1'b1;
          err_d   = hresp;
          pend_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        htrans_d = TRANS_IDLE;
        pend_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight beats.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      htrans_q   <= TRANS_IDLE;
      hburst_q   <= BURST_SINGLE;
      pend_q     <= 1'b0;
      pend_off_q <= '0;
      rv_q       <= 1'b0;
      rdata_q    <= '0;
      roff_q     <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      htrans_q   <= htrans_d;
      hburst_q   <= hburst_d;
      pend_q     <= pend_d;
      pend_off_q <= pend_off_d;
      rv_q       <= rv_d;
      rdata_q    <= rdata_d;
      roff_q     <= roff_d;
      last_q     <= last_d;
      err_q      <= err_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign haddr        = ag_haddr;
  assign htrans       = htrans_q;
  assign hburst       = hburst_q;
  assign hwrite       = 1'b0;
  assign hsize        = HSIZE_WORD;
  assign rdata_valid  = rv_q;
  assign rdata        = rdata_q;
  assign rdata_offset = roff_q;
  assign rdata_last   = last_q;
  assign rdata_err    = err_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
// tb_ahb_burst_master: random and directed refill traffic against a transaction-level AHB model.
// Latency: outputs compared every cycle on the falling edge.
// Backpressure: bench slave inserts random wait states and two-cycle ERROR responses.
module tb_ahb_burst_master;
  import interface_pkg::*;

  localparam int LOGN = 16384;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_burst;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        hready, hresp;
  logic [31:0] hrdata;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic [3:0]  rdata_offset;
  logic        rdata_last, rdata_err;

  ahb_burst_master dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_addr(req_addr), .req_burst(req_burst),
    .req_ready(req_ready), .haddr(haddr), .htrans(htrans), .hburst(hburst), .hwrite(hwrite),
    .hsize(hsize), .hready(hready), .hresp(hresp), .hrdata(hrdata), .rdata_valid(rdata_valid),
    .rdata(rdata), .rdata_offset(rdata_offset), .rdata_last(rdata_last), .rdata_err(rdata_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  burst;
    int          gap;
  } req_t;

  req_t        rq[$];
  logic [31:0] m_aq[$];
  logic [1:0]  m_tq[$];
  logic [2:0]  m_burst;
  bit          m_busy, m_dp, m_err2;
  logic [3:0]  m_dp_off;
  int          m_dp_idx, m_issue_idx, m_waits;
  bit          e_rv, e_last, e_err;
  logic [31:0] e_rdata;
  logic [3:0]  e_off;
  bit          rand_mode;
  int          d_wait_beat, d_wait_n, d_err_beat;
  int          cyc;
  int          acc_q[$];
  int          n_vec, n_bad;

  logic [31:0] lg_addr [LOGN];
  logic [1:0]  lg_tr   [LOGN];
  logic [3:0]  lg_off  [LOGN];
  logic        lg_rv   [LOGN];
  logic        lg_last [LOGN];
  logic        lg_err  [LOGN];
  logic        lg_rdy  [LOGN];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [31:0] addr, input logic [2:0] burst, input int gap);
    req_t r;
    r.addr = addr; r.burst = burst; r.gap = gap;
    rq.push_back(r);
  endtask

  task automatic model_reset();
    m_aq.delete(); m_tq.delete(); rq.delete();
    m_busy = 0; m_dp = 0; m_err2 = 0; m_waits = 0; e_rv = 0;
    m_dp_idx = 0; m_issue_idx = 0;
  endtask

  // One bus cycle: compare outputs, drive inputs, then advance the model across the next edge.
  task automatic step();
    bit          addr_done, data_done, busy_b;
    logic [31:0] base;
    int          off, n;
    chk("req_ready", 32'(req_ready), 32'(!m_busy));
    chk("rdata_valid", 32'(rdata_valid), 32'(e_rv));
    if (e_rv) begin
      chk("rdata", rdata, e_rdata);
      chk("rdata_offset", 32'(rdata_offset), 32'(e_off));
      chk("rdata_last", 32'(rdata_last), 32'(e_last));
      chk("rdata_err", 32'(rdata_err), 32'(e_err));
    end
    if (m_aq.size() > 0) begin
      chk("htrans", 32'(htrans), 32'(m_tq[0]));
      chk("haddr", haddr, m_aq[0]);
      chk("hburst", 32'(hburst), 32'(m_burst));
    end else begin
      chk("htrans_idle", 32'(htrans), 32'(TRANS_IDLE));
    end
    chk("hwrite", 32'(hwrite), 32'd0);
    chk("hsize", 32'(hsize), 32'd2);
    if (cyc < LOGN) begin
      lg_addr[cyc] = haddr; lg_tr[cyc] = htrans; lg_off[cyc] = rdata_offset;
      lg_rv[cyc] = rdata_valid; lg_last[cyc] = rdata_last; lg_err[cyc] = rdata_err;
      lg_rdy[cyc] = req_ready;
    end

    if (rq.size() > 0 && rq[0].gap == 0) begin
      req_valid = 1'b1; req_addr = rq[0].addr; req_burst = rq[0].burst;
    end else begin
      req_valid = 1'b0; req_addr = $urandom; req_burst = 3'($urandom);
    end
    hrdata = $urandom;
    if (m_err2) begin
      hready = 1'b1; hresp = 1'b1;
    end else if (m_dp && m_dp_idx == d_err_beat) begin
      hready = 1'b0; hresp = 1'b1;
    end else if (m_dp && m_dp_idx == d_wait_beat && m_waits < d_wait_n) begin
      hready = 1'b0; hresp = 1'b0;
    end else if (rand_mode && m_dp && $urandom_range(0, 15) == 0) begin
      hready = 1'b0; hresp = 1'b1;
    end else if (rand_mode) begin
      hready = ($urandom_range(0, 3) != 0); hresp = 1'b0;
    end else begin
      hready = 1'b1; hresp = 1'b0;
    end

    busy_b    = m_busy;
    addr_done = (m_aq.size() > 0) && hready;
    data_done = m_dp && hready;
    e_rv      = data_done;
    if (data_done) begin
      e_rdata = hrdata; e_off = m_dp_off; e_err = hresp; e_last = !addr_done;
      if (!addr_done) m_busy = 0;
    end
    if (m_dp && !hready) m_waits++;
    if (m_dp && !hready && hresp) begin
      m_aq.delete(); m_tq.delete(); m_err2 = 1;
    end else begin
      m_err2 = 0;
    end
    if (data_done) m_dp = 0;
    if (addr_done) begin
      m_dp = 1; m_dp_off = m_aq[0][3:0]; m_dp_idx = m_issue_idx; m_issue_idx++; m_waits = 0;
      void'(m_aq.pop_front()); void'(m_tq.pop_front());
    end
    if (rq.size() > 0) begin
      if (rq[0].gap > 0) begin
        rq[0].gap = rq[0].gap - 1;
      end else if (!busy_b) begin
        base = rq[0].addr - (rq[0].addr % 32'd16);
        off  = int'((rq[0].addr % 32'd16) / 32'd4) * 4;
        n    = (rq[0].burst == BURST_WRAP4) ? 4 : 1;
        for (int i = 0; i < n; i++) begin
          m_aq.push_back(base + 32'((off + 4 * i) % 16));
          m_tq.push_back((i == 0) ? TRANS_NONSEQ : TRANS_SEQ);
        end
        m_burst = (n == 4) ? BURST_WRAP4 : BURST_SINGLE;
        m_busy = 1; m_issue_idx = 0;
        acc_q.push_back(cyc);
        void'(rq.pop_front());
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      step();
    end
  endtask

  initial begin
    logic [31:0] ea [4];
    logic [1:0]  et [5];
    logic [3:0]  eo [4];
    int          ec [4];
    int          a, b, guard;
    n_vec = 0; n_bad = 0; cyc = 0; rand_mode = 0;
    d_wait_beat = -1; d_wait_n = 0; d_err_beat = -1;
    req_valid = 0; req_addr = '0; req_burst = '0; hready = 1; hresp = 0; hrdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_htrans", 32'(htrans), 32'd0);
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_hburst", 32'(hburst), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rdata_offset", 32'(rdata_offset), 32'd0);
    chk("rst_last_err", 32'({rdata_last, rdata_err}), 32'd0);
    rstn = 1'b1;
    step();

    // WRAP4 from the middle of a line, zero wait.
    acc_q.delete(); push(32'h1008, BURST_WRAP4, 0); run(10);
    chk("t1_accepted", acc_q.size(), 1);
    if (acc_q.size() > 0) begin
      a = acc_q[0];
      ea = '{32'h1008, 32'h100C, 32'h1000, 32'h1004};
      et = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b00};
      eo = '{4'h8, 4'hC, 4'h0, 4'h4};
      for (int k = 0; k < 4; k++) chk("t1_haddr", lg_addr[a + 1 + k], ea[k]);
      for (int k = 0; k < 5; k++) chk("t1_htrans", 32'(lg_tr[a + 1 + k]), 32'(et[k]));
      for (int k = 0; k < 4; k++) begin
        chk("t1_rv", 32'(lg_rv[a + 3 + k]), 32'd1);
        chk("t1_off", 32'(lg_off[a + 3 + k]), 32'(eo[k]));
      end
      chk("t1_last5", 32'(lg_last[a + 5]), 32'd0);
      chk("t1_last6", 32'(lg_last[a + 6]), 32'd1);
      chk("t1_rdy5", 32'(lg_rdy[a + 5]), 32'd0);
      chk("t1_rdy6", 32'(lg_rdy[a + 6]), 32'd1);
      chk("t1_rv7", 32'(lg_rv[a + 7]), 32'd0);
    end

    // SINGLE with unaligned low bits.
    acc_q.delete(); push(32'h2006, BURST_SINGLE, 0); run(6);
    chk("t2_accepted", acc_q.size(), 1);
    if (acc_q.size() > 0) begin
      a = acc_q[0];
      chk("t2_haddr", lg_addr[a + 1], 32'h2004);
      chk("t2_nonseq", 32'(lg_tr[a + 1]), 32'd2);
      chk("t2_idle", 32'(lg_tr[a + 2]), 32'd0);
      chk("t2_rv", 32'({lg_rv[a + 3], lg_last[a + 3], lg_rdy[a + 3]}), 32'b111);
      chk("t2_off", 32'(lg_off[a + 3]), 32'd4);
      chk("t2_rv4", 32'(lg_rv[a + 4]), 32'd0);
    end

    // Two wait states on the second beat's data phase.
    d_wait_beat = 1; d_wait_n = 2;
    acc_q.delete(); push(32'h3000, BURST_WRAP4, 0); run(12);
    d_wait_beat = -1; d_wait_n = 0;
    chk("t3_accepted", acc_q.size(), 1);
    if (acc_q.size() > 0) begin
      a = acc_q[0];
      for (int k = 3; k <= 5; k++) begin
        chk("t3_haddr_held", lg_addr[a + k], 32'h3008);
        chk("t3_seq_held", 32'(lg_tr[a + k]), 32'd3);
      end
      ec = '{3, 6, 7, 8};
      eo = '{4'h0, 4'h4, 4'h8, 4'hC};
      for (int k = 0; k < 4; k++) begin
        chk("t3_rv", 32'(lg_rv[a + ec[k]]), 32'd1);
        chk("t3_off", 32'(lg_off[a + ec[k]]), 32'(eo[k]));
      end
      chk("t3_rv_gap", 32'({lg_rv[a + 4], lg_rv[a + 5]}), 32'd0);
      chk("t3_last8", 32'(lg_last[a + 8]), 32'd1);
    end

    // ERROR on the first beat cancels the rest of the burst.
    d_err_beat = 0;
    acc_q.delete(); push(32'h4004, BURST_WRAP4, 0); run(8);
    d_err_beat = -1;
    chk("t4_accepted", acc_q.size(), 1);
    if (acc_q.size() > 0) begin
      a = acc_q[0];
      chk("t4_seq2", 32'(lg_tr[a + 2]), 32'd3);
      chk("t4_idle3", 32'(lg_tr[a + 3]), 32'd0);
      chk("t4_rv3", 32'(lg_rv[a + 3]), 32'd0);
      chk("t4_beat", 32'({lg_rv[a + 4], lg_err[a + 4], lg_last[a + 4], lg_rdy[a + 4]}), 32'b1111);
      chk("t4_off", 32'(lg_off[a + 4]), 32'd4);
      chk("t4_rv5", 32'(lg_rv[a + 5]), 32'd0);
    end

    // Asynchronous reset in cycle 3 of a WRAP4, then a fresh SINGLE.
    acc_q.delete(); push(32'h1000, BURST_WRAP4, 0); run(4);
    #2 rstn = 1'b0;
    #1;
    chk("t5_rst_htrans", 32'(htrans), 32'd0);
    chk("t5_rst_rv", 32'(rdata_valid), 32'd0);
    chk("t5_rst_ready", 32'(req_ready), 32'd1);
    chk("t5_rst_haddr", haddr, 32'd0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    step();
    acc_q.delete(); push(32'h5000, BURST_SINGLE, 0); run(6);
    chk("t5_accepted", acc_q.size(), 1);
    if (acc_q.size() > 0) begin
      a = acc_q[0];
      chk("t5_haddr", lg_addr[a + 1], 32'h5000);
      chk("t5_rv", 32'({lg_rv[a + 3], lg_last[a + 3], lg_err[a + 3]}), 32'b110);
      chk("t5_off", 32'(lg_off[a + 3]), 32'd0);
    end

    // Back-to-back: second request held valid until the engine is idle again.
    acc_q.delete(); push(32'h6000, BURST_WRAP4, 0); push(32'h7004, BURST_INCR4, 0); run(14);
    chk("t6_accepted", acc_q.size(), 2);
    if (acc_q.size() > 1) begin
      a = acc_q[0];
      b = acc_q[1];
      chk("t6_rdy5", 32'(lg_rdy[a + 5]), 32'd0);
      chk("t6_rdy6", 32'(lg_rdy[a + 6]), 32'd1);
      chk("t6_idle6", 32'(lg_tr[a + 6]), 32'd0);
      chk("t6_nonseq7", 32'(lg_tr[a + 7]), 32'd2);
      chk("t6_haddr7", lg_addr[a + 7], 32'h7004);
      chk("t6_incr4_single", 32'({lg_tr[b + 2], lg_rv[b + 3], lg_last[b + 3]}), 32'b0011);
    end

    // Randomized traffic with waits and errors.
    rand_mode = 1;
    for (int i = 0; i < 400; i++)
      push($urandom, ($urandom_range(0, 1) == 1) ? BURST_WRAP4 : 3'($urandom_range(0, 7)),
           int'($urandom_range(0, 3)));
    guard = 0;
    while ((rq.size() > 0 || m_busy) && guard < 30000) begin
      run(1);
      guard++;
    end
    if (guard >= 30000) begin
      n_vec++;
      n_bad++;
      $display("FAIL random_drain: still busy after %0d cycles, required idle", guard);
    end
    rand_mode = 0;
    run(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
